// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder operand stream.
package serial_adder_pkg;

  localparam int SA_W = 8;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Lengths of zero or beyond the operand width mean "send the whole word".
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
    logic [31:0] res;
    if ((len == 32'd0) || (len > max_len)) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_result_capture.sv
// Collects the serial adder's sum bits back into a parallel result word.
module serial_result_capture
  import serial_adder_pkg::*;
#(
  parameter int W     = SA_W,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic         last,
  input  logic         sum,
  output logic         res_valid,
  output logic [W-1:0] res_sum
);

  logic [LEN_W-1:0] idx_r;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     res_sum_r;
  logic             res_valid_r;
  logic [W-1:0]     mask_s;
  logic [W-1:0]     base_s;
  logic [W-1:0]     acc_next_s;

  // Bit 0 of a word starts from a clean accumulator so stale high bits never leak.
  always_comb begin
    mask_s = W'(1'b1) << idx_r;
    if (idx_r == LEN_W'(0)) begin
      base_s = {W{1'b0}};
    end else begin
      base_s = acc_r;
    end
    if (sum) begin
      acc_next_s = base_s | mask_s;
    end else begin
      acc_next_s = base_s;
    end
  end

  // Index/accumulate per valid bit; publish and pulse on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= {LEN_W{1'b0}};
      acc_r       <= {W{1'b0}};
      res_sum_r   <= {W{1'b0}};
      res_valid_r <= 1'b0;
    end else if (vld && last) begin
      idx_r       <= {LEN_W{1'b0}};
      acc_r       <= {W{1'b0}};
      res_sum_r   <= acc_next_s;
      res_valid_r <= 1'b1;
    end else if (vld) begin
      idx_r       <= idx_r + LEN_W'(1);
      acc_r       <= acc_next_s;
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;

endmodule

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand feeder for the serial adder (LSB first, vld/last framing).
// Optional result capture ports are enabled by defining SERIAL_RESULT_CAPTURE_EN.
module serial_operand_serializer
  import serial_adder_pkg::*;
#(
  parameter int W     = SA_W,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [LEN_W-1:0] in_len,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
`ifdef SERIAL_RESULT_CAPTURE_EN
  ,
  input  logic             sum,
  output logic             res_valid,
  output logic [W-1:0]     res_sum
`endif
);

  ser_state_t       state_r;
  logic [W-1:0]     sreg_a_r;
  logic [W-1:0]     sreg_b_r;
  logic [LEN_W-1:0] cnt_r;
  logic             vld_r;
  logic             a_r;
  logic             b_r;
  logic             last_r;
  logic [LEN_W-1:0] len_s;
  logic             ready_s;
  logic             accept_s;

  // Ready in IDLE, or on the final bit so the next word follows without a bubble.
  always_comb begin
    len_s = LEN_W'(clamp_len(32'(in_len), 32'(W)));
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (state_r == SER_IDLE) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (state_r == SER_SHIFT) && last_r;
    end
    accept_s = in_valid && ready_s;
  end

  // Bit 0 goes out directly from the load; cnt_r tracks bits still to send after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= SER_IDLE;
      sreg_a_r <= {W{1'b0}};
      sreg_b_r <= {W{1'b0}};
      cnt_r    <= {LEN_W{1'b0}};
      vld_r    <= 1'b0;
      a_r      <= 1'b0;
      b_r      <= 1'b0;
      last_r   <= 1'b0;
    end else if (accept_s) begin
      state_r  <= SER_SHIFT;
      sreg_a_r <= in_a >> 1;
      sreg_b_r <= in_b >> 1;
      cnt_r    <= len_s - LEN_W'(1);
      vld_r    <= 1'b1;
      a_r      <= in_a[0];
      b_r      <= in_b[0];
      last_r   <= (len_s == LEN_W'(1));
    end else if ((state_r == SER_SHIFT) && !last_r) begin
      state_r  <= SER_SHIFT;
      sreg_a_r <= sreg_a_r >> 1;
      sreg_b_r <= sreg_b_r >> 1;
      cnt_r    <= cnt_r - LEN_W'(1);
      vld_r    <= 1'b1;
      a_r      <= sreg_a_r[0];
      b_r      <= sreg_b_r[0];
      last_r   <= (cnt_r == LEN_W'(1));
    end else begin
      state_r  <= SER_IDLE;
      sreg_a_r <= {W{1'b0}};
      sreg_b_r <= {W{1'b0}};
      cnt_r    <= {LEN_W{1'b0}};
      vld_r    <= 1'b0;
      a_r      <= 1'b0;
      b_r      <= 1'b0;
      last_r   <= 1'b0;
    end
  end

  assign in_ready = ready_s;
  assign vld      = vld_r;
  assign a        = a_r;
  assign b        = b_r;
  assign last     = last_r;

`ifdef SERIAL_RESULT_CAPTURE_EN
  serial_result_capture #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld_r),
    .last      (last_r),
    .sum       (sum),
    .res_valid (res_valid),
    .res_sum   (res_sum)
  );
`endif

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed, table-driven bench for serial_operand_serializer (W=8).
module tb_serial_operand_serializer;

  localparam int W     = 8;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [LEN_W-1:0] in_len;
  logic             vld;
  logic             a;
  logic             b;
  logic             last;
  logic             sum;
  logic             res_valid;
  logic [W-1:0]     res_sum;

  int checks;
  int failures;
  logic carry;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] len;
    int         exp_len;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  serial_operand_serializer #(.W(W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_len   (in_len),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .last     (last)
`ifdef SERIAL_RESULT_CAPTURE_EN
    ,
    .sum       (sum),
    .res_valid (res_valid),
    .res_sum   (res_sum)
`endif
  );

`ifndef SERIAL_RESULT_CAPTURE_EN
  assign res_valid = 1'b0;
  assign res_sum   = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial adder model: drive sum for the bit pair currently on the wires.
  task automatic drive_sum(input logic ab, input logic bb);
    sum   = ab ^ bb ^ carry;
    carry = (ab & bb) | (carry & (ab ^ bb));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  task automatic run_word(input vec_t v, input string tag);
    wait_ready();
    in_a     = v.a;
    in_b     = v.b;
    in_len   = v.len;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    carry    = 1'b0;
    for (int i = 0; i < v.exp_len; i++) begin
      chk({tag, "_vld"}, vld, 1);
      chk({tag, "_a"}, a, v.a[i]);
      chk({tag, "_b"}, b, v.b[i]);
      chk({tag, "_last"}, last, (i == v.exp_len - 1) ? 1 : 0);
      drive_sum(v.a[i], v.b[i]);
      step();
    end
    sum = 1'b0;
    chk({tag, "_vld_end"}, vld, 0);
    chk({tag, "_last_end"}, last, 0);
`ifdef SERIAL_RESULT_CAPTURE_EN
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_sum"}, res_sum, v.exp_res);
`endif
    for (int g = 0; g < 3; g++) begin
      step();
      chk({tag, "_gap_out"}, {vld, a, b, last}, 0);
      chk({tag, "_gap_ready"}, in_ready, 1);
`ifdef SERIAL_RESULT_CAPTURE_EN
      chk({tag, "_gap_res_valid"}, res_valid, 0);
      chk({tag, "_gap_res_sum"}, res_sum, v.exp_res);
`endif
    end
  endtask

  task automatic run_back_to_back();
    logic [7:0] wa[2];
    logic [7:0] wb[2];
    int         wi;
    int         bi;
    wa[0] = 8'h01; wb[0] = 8'h01;
    wa[1] = 8'hFF; wb[1] = 8'h01;
    wait_ready();
    in_a = wa[0]; in_b = wb[0]; in_len = 4'd8; in_valid = 1'b1;
    step();
    in_a  = wa[1];
    in_b  = wb[1];
    carry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wi = i / 8;
      bi = i % 8;
      if (i == 8) begin
        in_valid = 1'b0;
        carry    = 1'b0;
`ifdef SERIAL_RESULT_CAPTURE_EN
        chk("b2b_res_valid1", res_valid, 1);
        chk("b2b_res_sum1", res_sum, 8'h02);
`endif
      end
      if (i == 3) chk("b2b_ready_mid", in_ready, 0);
      if (i == 7) chk("b2b_ready_last", in_ready, 1);
      chk("b2b_vld", vld, 1);
      chk("b2b_a", a, wa[wi][bi]);
      chk("b2b_b", b, wb[wi][bi]);
      chk("b2b_last", last, (bi == 7) ? 1 : 0);
      drive_sum(wa[wi][bi], wb[wi][bi]);
      step();
    end
    sum = 1'b0;
    chk("b2b_vld_end", vld, 0);
`ifdef SERIAL_RESULT_CAPTURE_EN
    chk("b2b_res_valid2", res_valid, 1);
    chk("b2b_res_sum2", res_sum, 8'h00);
`endif
    step();
  endtask

  task automatic run_reset_mid_word();
    logic [7:0] v;
    v = 8'hFF;
    wait_ready();
    in_a = v; in_b = v; in_len = 4'd8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rst_pre_vld", {vld, a, b}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", {vld, a, b, last}, 0);
    chk("rst_ready_low", in_ready, 0);
    step();
    step();
    chk("rst_hold_out", {vld, a, b, last}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_high", in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rst_no_vld", vld, 0);
      chk("rst_no_res_valid", res_valid, 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    carry    = 1'b0;
    sum      = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_len   = '0;

    vecs[0] = '{a: 8'h35, b: 8'h0F, len: 4'd8, exp_len: 8, exp_res: 8'h44};
    vecs[1] = '{a: 8'h01, b: 8'h01, len: 4'd1, exp_len: 1, exp_res: 8'h00};
    vecs[2] = '{a: 8'hA5, b: 8'h3C, len: 4'd0, exp_len: 8, exp_res: 8'hE1};
    vecs[3] = '{a: 8'h5A, b: 8'hC3, len: 4'd9, exp_len: 8, exp_res: 8'h1D};
    vecs[4] = '{a: 8'h07, b: 8'h05, len: 4'd3, exp_len: 3, exp_res: 8'h04};
    vecs[5] = '{a: 8'hF0, b: 8'h0F, len: 4'd5, exp_len: 5, exp_res: 8'h1F};

    step();
    step();
    chk("reset_out", {vld, a, b, last}, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_sum", res_sum, 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", in_ready, 1);
    step();

    for (int k = 0; k < 6; k++) begin
      run_word(vecs[k], $sformatf("vec%0d", k));
    end

    run_back_to_back();
    run_reset_mid_word();
    run_word(vecs[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
